// File: rtl/cl_pkg.sv
// rtl/cl_pkg.sv - shared op encodings, FSM state type and mask helpers for the logic-cell op decoder
package cl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam logic [1:0] OP_AND = 2'd0;
    localparam logic [1:0] OP_OR  = 2'd1;
    localparam logic [1:0] OP_XOR = 2'd2;
    localparam logic [1:0] OP_NOT = 2'd3;

    function automatic logic [2:0] popcount4(input logic [3:0] m);
        return {2'b00, m[0]} + {2'b00, m[1]} + {2'b00, m[2]} + {2'b00, m[3]};
    endfunction

    // Lowest surviving candidate wins; an empty mask reports OP_AND.
    function automatic logic [1:0] lowest_op(input logic [3:0] m);
        if (m[0])      return OP_AND;
        else if (m[1]) return OP_OR;
        else if (m[2]) return OP_XOR;
        else if (m[3]) return OP_NOT;
        else           return OP_AND;
    endfunction

endpackage

// File: rtl/cl_op_decoder_if.sv
// rtl/cl_op_decoder_if.sv - sample handshake and result bus of the logic-cell op decoder
interface cl_op_decoder_if;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic       a;
    logic       b;
    logic       y;
    logic       done;
    logic [1:0] op;
    logic       is_unique;
    logic       none;
    logic [3:0] cand;
    logic       timeout;

    modport master (
        output start, in_valid, a, b, y,
        input  in_ready, done, op, is_unique, none, cand, timeout
    );

    modport slave (
        input  start, in_valid, a, b, y,
        output in_ready, done, op, is_unique, none, cand, timeout
    );
endinterface

// File: rtl/cl_match.sv
// rtl/cl_match.sv - per-op consistency of one (a, b, y) sample against all four logic-cell ops
module cl_match
    import cl_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       y,
    output logic [3:0] match
);

    assign match[OP_AND] = ((a & b) == y);
    assign match[OP_OR]  = ((a | b) == y);
    assign match[OP_XOR] = ((a ^ b) == y);
    assign match[OP_NOT] = ((~a) == y);

endmodule

// File: rtl/cl_op_decoder.sv
// rtl/cl_op_decoder.sv - identifies a logic-cell op from observed samples; CL_OP_DECODER_TIMEOUT_EN adds an inactivity abort
module cl_op_decoder
    import cl_pkg::*;
#(
    parameter int MAX_SAMPLES    = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    cl_op_decoder_if.slave  bus
);

    state_t     state, state_nxt;
    logic [3:0] cand, cand_upd, match;
    logic [3:0] count;
    logic       accept, decide, tmo_hit;

    cl_match u_match (
        .a     (bus.a),
        .b     (bus.b),
        .y     (bus.y),
        .match (match)
    );

    // A sample arriving together with start belongs to the aborted run and is dropped.
    assign accept   = bus.in_valid && (state == ST_COLLECT) && !bus.start;
    assign cand_upd = cand & match;
    assign decide   = accept && ((popcount4(cand_upd) <= 3'd1) ||
                                 ((count + 4'd1) == 4'(MAX_SAMPLES)));

`ifdef CL_OP_DECODER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt;
    logic          timeout_q;

    always_ff @(posedge clk) begin
        if (!rst_n || bus.start || accept || state != ST_COLLECT)
            idle_cnt <= '0;
        else if (idle_cnt != TW'(TIMEOUT_CYCLES))
            idle_cnt <= idle_cnt + 1'b1;
    end

    assign tmo_hit = (state == ST_COLLECT) && !bus.start && !accept &&
                     (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || bus.start)
            timeout_q <= 1'b0;
        else if (tmo_hit)
            timeout_q <= 1'b1;
    end

    assign bus.timeout = timeout_q;
`else
    assign tmo_hit     = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (bus.start) state_nxt = ST_COLLECT;
            ST_COLLECT: begin
                if (bus.start)             state_nxt = ST_COLLECT;
                else if (decide || tmo_hit) state_nxt = ST_DONE;
            end
            ST_DONE:    if (bus.start) state_nxt = ST_COLLECT;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || bus.start) begin
            cand  <= 4'b1111;
            count <= 4'd0;
        end else if (accept) begin
            cand <= cand_upd;
            if (count != 4'(MAX_SAMPLES))
                count <= count + 4'd1;
        end
    end

    always_comb begin
        bus.in_ready  = (state == ST_COLLECT);
        bus.done      = 1'b0;
        bus.op        = 2'b00;
        bus.is_unique = 1'b0;
        bus.none      = 1'b0;
        if (state == ST_DONE) begin
            bus.done      = 1'b1;
            bus.op        = lowest_op(cand);
            bus.is_unique = (popcount4(cand) == 3'd1);
            bus.none      = (cand == 4'b0000);
        end
    end

    assign bus.cand = cand;

endmodule

// File: doc/cl_op_decoder.md
CL_OP_DECODER -- requirements
Module: cl_op_decoder

Interface
REQ-001 SHALL have parameter MAX_SAMPLES, default 8: maximum accepted samples per identification, range 1..15.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16: idle cycles in COLLECT before abort; used only when timeout is compiled in.
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  begin a new identification.
- in_valid  in  1  sample (a, b, y) valid.
- in_ready  out  1  block accepts a sample.
- a, b  in  1 each  logic-cell operand bits.
- y  in  1  observed logic-cell output.
- done  out  1  identification finished; held.
- op  out  2  identified select: 00 AND, 01 OR, 10 XOR, 11 NOT a.
- unique  out  1  exactly one op is consistent.
- none  out  1  no op is consistent.
- cand  out  4  candidate mask; bit k set means op k is consistent.
- timeout  out  1  COLLECT aborted on inactivity.

Function
REQ-004 SHALL clear mask bit k on a sample when op k applied to (a, b) differs from y; mask bits SHALL never be set except at start.
REQ-005 SHALL implement FSM IDLE, COLLECT, DONE.
- IDLE: in_ready=0; start moves to COLLECT with cand=1111 and count=0.
REQ-006 In COLLECT, in_ready SHALL be 1.
- Sample accepted when in_valid&in_ready.
- On accept: cand <= cand & match; count <= count+1.
REQ-007 SHALL move COLLECT->DONE on the edge after an accept when the updated cand has popcount<=1 or the updated count equals MAX_SAMPLES.
- done asserts the cycle after the deciding accept (latency 1).
REQ-008 In DONE:
- done=1, in_ready=0, cand frozen.
- op = index of lowest set cand bit, or 00 if cand=0000.
- unique=(popcount==1); none=(cand==0000).
REQ-009 start in DONE or COLLECT SHALL restart COLLECT (cand=1111, count=0, done=0, timeout=0).
- A sample presented in the same cycle as start is discarded.
REQ-010 done, op, unique and none SHALL be 0 outside DONE; cand SHALL be visible in all states.
REQ-011 count SHALL saturate at MAX_SAMPLES and never wrap.

Reset
REQ-012 rst_n=0 at a clock edge, in any state including mid-COLLECT, SHALL force:
- state IDLE, cand=1111, count=0.
- done, op, unique, none, timeout and in_ready = 0.

Configuration
REQ-013 Macro CL_OP_DECODER_TIMEOUT_EN compiles in inactivity timeout:
- Defined: cycle counter reset on each accept; after TIMEOUT_CYCLES consecutive COLLECT cycles without accept, moves to DONE with timeout=1, outputs per REQ-008.
- Undefined: no counter logic; timeout tied 0; COLLECT waits indefinitely.

Structure
REQ-014 Shared package cl_pkg SHALL hold:
- op encoding constants OP_AND, OP_OR, OP_XOR, OP_NOT (matching the logic-cell select).
- FSM state typedef.
REQ-015 SHALL instantiate one combinational sub-module cl_match(a, b, y -> 4-bit match), evaluating all four logic-cell ops.

Verification
REQ-016 Start; feed (1,1,0), (0,1,1), (1,0,1) -> cand 1100, 1100, 0100; done one cycle after third accept; op=10, unique=1.
REQ-017 Start; feed (1,1,1), (1,1,0) -> cand 0011 then 0000; done, none=1, unique=0, op=00.
REQ-018 Start; feed (1,1,1) eight times with MAX_SAMPLES=8 -> done after 8th accept; cand=0011, op=00, unique=0.
REQ-019 In COLLECT with cand=0011, pulse start with in_valid=1 -> cand=1111, count=0, sample ignored; then (0,0,1) -> op=11, unique=1.
REQ-020 rst_n=0 for one cycle mid-COLLECT -> next cycle IDLE, cand=1111, all other outputs 0; in_valid ignored until start.
REQ-021 With CL_OP_DECODER_TIMEOUT_EN, TIMEOUT_CYCLES=16: start, one accept (1,1,1), then 16 idle cycles -> done=1, timeout=1, cand=0011.
